// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-requester arbiter onto a single peripheral register bus.
// Latency: req at cycle N -> write strobe at N+3, ack at N+4 (read ack at N+3+READ_WAIT).
// Backpressure: busy0/busy1 high from latch to end of DONE; a req while busy is dropped.
// Ports: clk/rst; per requester req/we/addr/wdata in, busy/ack/rdata out;
//        peripheral side address/data_write/data_in out, data_out in; grant out.
// Option: define ARB_ROUND_ROBIN_EN for round-robin on contention (default is
//         fixed priority, requester 0 wins).
module reg_bus_arbiter #(
   parameter int READ_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       we0,
   input  logic [3:0] addr0,
   input  logic [7:0] wdata0,
   input  logic       req1,
   input  logic       we1,
   input  logic [3:0] addr1,
   input  logic [7:0] wdata1,
   output logic       busy0,
   output logic       busy1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rdata0,
   output logic [7:0] rdata1,
   output logic [3:0] address,
   output logic       data_write,
   output logic [7:0] data_in,
   input  logic [7:0] data_out,
   output logic       grant
);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_t;
   localparam logic [2:0] RW = 3'(READ_WAIT);

   state_t     state_q;
   logic [1:0] pend_q;      // latched but not yet granted
   logic [1:0] busy_q;      // latched or in service
   logic [1:0] slot_we_q;
   logic [3:0] slot_addr_q  [2];
   logic [7:0] slot_wdata_q [2];
   logic [2:0] cnt_q;
   logic       grant_q;
   logic       ack0_q, ack1_q, dw_q;
   logic [3:0] address_q;
   logic [7:0] data_in_q, rdata0_q, rdata1_q;
   logic       sel_d;

`ifdef ARB_ROUND_ROBIN_EN
   // rr_q names the requester favoured on the next contention.
   logic rr_q;
   always_comb sel_d = (&pend_q) ? rr_q : pend_q[1];
`else
   always_comb sel_d = ~pend_q[0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         pend_q          <= 2'b00;
         busy_q          <= 2'b00;
         slot_we_q       <= 2'b00;
         slot_addr_q[0]  <= 4'h0;
         slot_addr_q[1]  <= 4'h0;
         slot_wdata_q[0] <= 8'h00;
         slot_wdata_q[1] <= 8'h00;
         cnt_q           <= 3'd0;
         grant_q         <= 1'b0;
         ack0_q          <= 1'b0;
         ack1_q          <= 1'b0;
         dw_q            <= 1'b0;
         address_q       <= 4'h0;
         data_in_q       <= 8'h00;
         rdata0_q        <= 8'h00;
         rdata1_q        <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
         rr_q            <= 1'b0;
`endif
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;

         // Slot capture; a busy requester's slot is never overwritten, so the
         // transaction in service keeps reading stable slot contents.
         if (req0 && !busy_q[0]) begin
            pend_q[0]       <= 1'b1;
            busy_q[0]       <= 1'b1;
            slot_we_q[0]    <= we0;
            slot_addr_q[0]  <= addr0;
            slot_wdata_q[0] <= wdata0;
         end
         if (req1 && !busy_q[1]) begin
            pend_q[1]       <= 1'b1;
            busy_q[1]       <= 1'b1;
            slot_we_q[1]    <= we1;
            slot_addr_q[1]  <= addr1;
            slot_wdata_q[1] <= wdata1;
         end

         case (state_q)
            IDLE: begin
               if (|pend_q) begin
                  grant_q       <= sel_d;
                  address_q     <= slot_addr_q[sel_d];
                  data_in_q     <= slot_wdata_q[sel_d];
                  pend_q[sel_d] <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                  // Pointer moves only when an arbitration decision was made,
                  // so the loser of a contention wins the next one.
                  if (&pend_q) rr_q <= ~sel_d;
`endif
                  state_q <= SETUP;
               end
            end
            SETUP: begin
               cnt_q   <= 3'd1;
               dw_q    <= slot_we_q[grant_q];
               state_q <= XFER;
            end
            XFER: begin
               if (slot_we_q[grant_q] || cnt_q == RW) begin
                  if (!slot_we_q[grant_q]) begin
                     if (grant_q) rdata1_q <= data_out;
                     else         rdata0_q <= data_out;
                  end
                  dw_q <= 1'b0;
                  if (grant_q) ack1_q <= 1'b1;
                  else         ack0_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
               end
            end
            DONE: begin
               busy_q[grant_q] <= 1'b0;
               state_q         <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy0      = busy_q[0];
   assign busy1      = busy_q[1];
   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata0     = rdata0_q;
   assign rdata1     = rdata1_q;
   assign address    = address_q;
   assign data_write = dw_q;
   assign data_in    = data_in_q;
   assign grant      = grant_q;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed bench for reg_bus_arbiter built with READ_WAIT=2.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_bus_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, we0, req1, we1;
   logic [3:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       busy0, busy1, ack0, ack1;
   logic [7:0] rdata0, rdata1;
   logic [3:0] address;
   logic       data_write;
   logic [7:0] data_in, data_out;
   logic       grant;

   always #5 clk = ~clk;

   reg_bus_arbiter #(.READ_WAIT(2)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .busy0(busy0), .busy1(busy1), .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1),
      .address(address), .data_write(data_write), .data_in(data_in),
      .data_out(data_out), .grant(grant)
   );

   typedef struct { logic id; logic [7:0] rdata; } ack_exp_t;
   typedef struct { logic [3:0] addr; logic [7:0] data; } wr_exp_t;

   ack_exp_t ack_q[$];
   wr_exp_t  wr_q[$];
   logic [7:0] rd_model [2];

   int vectors = 0;
   int errors  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_write(input logic id, input logic [3:0] a, input logic [7:0] d);
      wr_exp_t  w;
      ack_exp_t e;
      w.addr = a; w.data = d;
      wr_q.push_back(w);
      e.id = id; e.rdata = rd_model[id];
      ack_q.push_back(e);
   endtask

   task automatic exp_read(input logic id, input logic [7:0] d);
      ack_exp_t e;
      rd_model[id] = d;
      e.id = id; e.rdata = d;
      ack_q.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!busy0 && !busy1) break;
         tick();
      end
      chk("idle_timeout", {30'b0, busy1, busy0}, 32'd0);
   endtask

   task automatic check_ack(input logic id);
      ack_exp_t e;
      chk("ack_expected", 32'(ack_q.size() != 0), 32'd1);
      if (ack_q.size() != 0) begin
         e = ack_q.pop_front();
         chk("ack_id", 32'(id), 32'(e.id));
         chk("ack_rdata", 32'(id ? rdata1 : rdata0), 32'(e.rdata));
      end
   endtask

   // Scoreboard monitor: every strobe and every ack must match the next expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (data_write) begin
            chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
               wr_exp_t w;
               w = wr_q.pop_front();
               chk("wr_addr", 32'(address), 32'(w.addr));
               chk("wr_data", 32'(data_in), 32'(w.data));
            end
         end
         if (ack0) check_ack(1'b0);
         if (ack1) check_ack(1'b1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic first;
      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = 4'h0; wdata0 = 8'h00;
      req1 = 1'b0; we1 = 1'b0; addr1 = 4'h0; wdata1 = 8'h00;
      data_out = 8'h00;
      rd_model[0] = 8'h00;
      rd_model[1] = 8'h00;

      // Reset state
      repeat (2) tick();
      chk("rst_busy0", 32'(busy0), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_ack", {30'b0, ack1, ack0}, 32'd0);
      chk("rst_dw", 32'(data_write), 32'd0);
      chk("rst_address", 32'(address), 32'd0);
      chk("rst_data_in", 32'(data_in), 32'd0);
      chk("rst_rdata0", 32'(rdata0), 32'd0);
      chk("rst_rdata1", 32'(rdata1), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      rst = 1'b0;
      tick();

      // Single write from requester 0: strobe at N+3, ack at N+4, idle at N+5
      exp_write(1'b0, 4'h3, 8'hA5);
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5;
      tick(); req0 = 1'b0;
      chk("w_busy0_n1", 32'(busy0), 32'd1);
      chk("w_dw_n1", 32'(data_write), 32'd0);
      tick();
      chk("w_dw_setup", 32'(data_write), 32'd0);
      chk("w_addr_setup", 32'(address), 32'h3);
      tick();
      chk("w_dw_n3", 32'(data_write), 32'd1);
      chk("w_addr_n3", 32'(address), 32'h3);
      chk("w_data_n3", 32'(data_in), 32'hA5);
      chk("w_grant_n3", 32'(grant), 32'd0);
      tick();
      chk("w_dw_n4", 32'(data_write), 32'd0);
      chk("w_ack0_n4", 32'(ack0), 32'd1);
      tick();
      chk("w_ack0_n5", 32'(ack0), 32'd0);
      chk("w_busy0_n5", 32'(busy0), 32'd0);

      // Read from requester 1, READ_WAIT=2: ack at N+5 with captured data
      data_out = 8'h3C;
      exp_read(1'b1, 8'h3C);
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'h7;
      tick(); req1 = 1'b0;
      repeat (3) begin
         tick();
         chk("r_ack1_early", 32'(ack1), 32'd0);
         chk("r_dw_low", 32'(data_write), 32'd0);
      end
      tick();
      chk("r_ack1_n5", 32'(ack1), 32'd1);
      chk("r_rdata1", 32'(rdata1), 32'h3C);
      chk("r_address", 32'(address), 32'h7);
      chk("r_grant", 32'(grant), 32'd1);
      tick();
      chk("r_ack1_n6", 32'(ack1), 32'd0);
      data_out = 8'hFF;
      repeat (3) tick();
      chk("r_rdata1_hold", 32'(rdata1), 32'h3C);
      chk("r_busy1_done", 32'(busy1), 32'd0);

      // Simultaneous writes: requester 0 wins the first contention
      exp_write(1'b0, 4'h1, 8'h11);
      exp_write(1'b1, 4'h2, 8'h22);
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h1; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'h2; wdata1 = 8'h22;
      tick(); req0 = 1'b0; req1 = 1'b0;
      chk("p1_busy", {30'b0, busy1, busy0}, 32'h3);
      tick(); tick();
      chk("p1_dw", 32'(data_write), 32'd1);
      chk("p1_grant", 32'(grant), 32'd0);
      chk("p1_address", 32'(address), 32'h1);
      wait_idle();

      // Repeat contention: round-robin hands it to 1, fixed priority to 0
`ifdef ARB_ROUND_ROBIN_EN
      first = 1'b1;
`else
      first = 1'b0;
`endif
      if (first) begin
         exp_write(1'b1, 4'h5, 8'h55);
         exp_write(1'b0, 4'h4, 8'h44);
      end else begin
         exp_write(1'b0, 4'h4, 8'h44);
         exp_write(1'b1, 4'h5, 8'h55);
      end
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h4; wdata0 = 8'h44;
      req1 = 1'b1; we1 = 1'b1; addr1 = 4'h5; wdata1 = 8'h55;
      tick(); req0 = 1'b0; req1 = 1'b0;
      tick(); tick();
      chk("p2_grant", 32'(grant), 32'(first));
      chk("p2_address", 32'(address), first ? 32'h5 : 32'h4);
      wait_idle();
      chk("p2_rdata1_kept", 32'(rdata1), 32'h3C);

      // Request while busy is dropped; req1 arriving in req0's DONE is served next
      exp_write(1'b0, 4'h2, 8'h33);
      req0 = 1'b1; we0 = 1'b1; addr0 = 4'h2; wdata0 = 8'h33;
      tick();
      addr0 = 4'h9; wdata0 = 8'h77; we0 = 1'b0;
      tick(); req0 = 1'b0;
      tick();
      chk("ig_dw", 32'(data_write), 32'd1);
      chk("ig_address", 32'(address), 32'h2);
      chk("ig_data_in", 32'(data_in), 32'h33);
      tick();
      chk("ig_ack0", 32'(ack0), 32'd1);
      data_out = 8'h5A;
      exp_read(1'b1, 8'h5A);
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'h5;
      tick(); req1 = 1'b0;
      chk("dn_busy1", 32'(busy1), 32'd1);
      chk("dn_busy0", 32'(busy0), 32'd0);
      repeat (3) tick();
      chk("dn_ack1_early", 32'(ack1), 32'd0);
      tick();
      chk("dn_ack1", 32'(ack1), 32'd1);
      chk("dn_rdata1", 32'(rdata1), 32'h5A);
      tick();
      wait_idle();

      // Reset during read XFER aborts with no ack and clears rdata
      data_out = 8'h99;
      req1 = 1'b1; we1 = 1'b0; addr1 = 4'h4;
      tick(); req1 = 1'b0;
      tick(); tick();
      chk("ab_in_xfer_busy1", 32'(busy1), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("ab_dw", 32'(data_write), 32'd0);
      chk("ab_busy1", 32'(busy1), 32'd0);
      chk("ab_ack", {30'b0, ack1, ack0}, 32'd0);
      chk("ab_rdata1", 32'(rdata1), 32'd0);
      chk("ab_address", 32'(address), 32'd0);
      rd_model[0] = 8'h00;
      rd_model[1] = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      repeat (8) tick();
      chk("ab_busy1_after", 32'(busy1), 32'd0);
      chk("ab_rdata1_after", 32'(rdata1), 32'd0);

      chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
      chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
